// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the PC and sequences one instruction fetch at a time.
// It holds each returned word for decode and applies branch and flush redirects.
// Ports:
//   clk, rst                    clock, async active-high reset
//   stall_i                     decode not ready; hold the current word
//   flush_i, new_pc_i           flush redirect pulse and its target
//   branch_flag_i, branch_target_i  branch redirect pulse and its target
//   ce_o                        imem chip enable
//   imem_req_o, imem_addr_o     fetch request and address (addr = pc)
//   imem_gnt_i                  request accepted
//   imem_rvalid_i, imem_rdata_i fetch response
//   if_valid_o, if_pc_o, if_inst_o  instruction delivered to IF/ID
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        ce_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inflight_pc;
  logic        discard;
  logic        redirect;
  logic [31:0] raw_tgt;
  logic [31:0] target;

  // Flush outranks branch; targets are forced word-aligned.
  assign redirect    = flush_i | branch_flag_i;
  assign raw_tgt     = flush_i ? new_pc_i : branch_target_i;
  assign target      = {raw_tgt[31:2], 2'b00};
  assign imem_addr_o = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inflight_pc <= 32'h0;
      discard     <= 1'b0;
      ce_o        <= 1'b0;
      imem_req_o  <= 1'b0;
      if_valid_o  <= 1'b0;
      if_pc_o     <= 32'h0;
      if_inst_o   <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          ce_o       <= 1'b1;
          imem_req_o <= 1'b1;
          state      <= REQ;
          if (redirect) pc <= target;
        end
        REQ: begin
          if (imem_gnt_i) begin
            // The old address is accepted even if a redirect
            // lands now; its response is then marked stale.
            inflight_pc <= pc;
            imem_req_o  <= 1'b0;
            state       <= WAIT;
            if (redirect) begin
              pc      <= target;
              discard <= 1'b1;
            end else begin
              pc <= pc + 32'd4;
            end
          end else if (redirect) begin
            pc <= target;
          end
        end
        WAIT: begin
          if (redirect) pc <= target;
          if (imem_rvalid_i) begin
            if (discard || redirect) begin
              discard    <= 1'b0;
              imem_req_o <= 1'b1;
              state      <= REQ;
            end else begin
              if_inst_o  <= imem_rdata_i;
              if_pc_o    <= inflight_pc;
              if_valid_o <= 1'b1;
              state      <= HOLD;
            end
          end else if (redirect) begin
            discard <= 1'b1;
          end
        end
        HOLD: begin
          // A redirect drops the held word even under stall.
          if (redirect || !stall_i) begin
            if_valid_o <= 1'b0;
            imem_req_o <= 1'b1;
            state      <= REQ;
            if (redirect) pc <= target;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed scenarios plus a randomized run
// against a PC-sequence reference model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RPC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, branch;
  logic [31:0] new_pc, btgt;
  logic        ce, req, gnt, rvalid;
  logic [31:0] addr, rdata;
  logic        ifv;
  logic [31:0] ifpc, ifinst;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall),
    .flush_i        (flush),
    .new_pc_i       (new_pc),
    .branch_flag_i  (branch),
    .branch_target_i(btgt),
    .ce_o           (ce),
    .imem_req_o     (req),
    .imem_addr_o    (addr),
    .imem_gnt_i     (gnt),
    .imem_rvalid_i  (rvalid),
    .imem_rdata_i   (rdata),
    .if_valid_o     (ifv),
    .if_pc_o        (ifpc),
    .if_inst_o      (ifinst)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic idle_inputs();
    stall  = 1'b0;
    flush  = 1'b0;
    branch = 1'b0;
    new_pc = 32'h0;
    btgt   = 32'h0;
    gnt    = 1'b0;
    rvalid = 1'b0;
    rdata  = 32'h0;
  endtask

  // Reset, then redirect from IDLE so the first request is at a.
  task automatic start_at(input logic [31:0] a);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    flush  = 1'b1;
    new_pc = a;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (ce !== 1'b0) begin
      n_bad++; $display("FAIL rst_ce: got %b want 0", ce);
    end
    n_cmp++;
    if (req !== 1'b0) begin
      n_bad++; $display("FAIL rst_req: got %b want 0", req);
    end
    n_cmp++;
    if (ifv !== 1'b0 || ifpc !== 32'h0 || ifinst !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_if: got %b %h %h want 0 0 0", ifv, ifpc, ifinst);
    end
    n_cmp++;
    if (addr !== RPC) begin
      n_bad++; $display("FAIL rst_addr: got %h want %h", addr, RPC);
    end
  endtask

  // Single-cycle gnt/rvalid from reset; pc wraps past 2^32.
  task automatic test_wrap_seq();
    logic [31:0] exp_pcs [5] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC,
                                 32'h0, 32'h4, 32'h8};
    logic [31:0] pcs [5];
    logic [31:0] ins [5];
    int          at [5];
    int          nd = 0;
    logic        pv = 1'b0;
    logic        granted = 1'b0;
    logic [31:0] gaddr = 32'h0;
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        n_cmp++;
        if (ce !== 1'b1 || req !== 1'b1) begin
          n_bad++; $display("FAIL seq_ce_c1: got ce=%b req=%b want 1 1", ce, req);
        end
      end
      if (ifv && !pv) begin
        if (nd < 5) begin
          pcs[nd] = ifpc;
          ins[nd] = ifinst;
          at[nd]  = cyc;
        end
        nd++;
      end
      pv     = ifv;
      rvalid = granted;
      rdata  = granted ? mem_word(gaddr) : 32'h0;
      gnt     = req;
      granted = req;
      gaddr   = addr;
    end
    idle_inputs();
    n_cmp++;
    if (nd < 5) begin
      n_bad++; $display("FAIL seq_count: got %0d want >=5", nd);
    end else begin
      n_cmp++;
      if (at[0] !== 3) begin
        n_bad++; $display("FAIL seq_first_cycle: got %0d want 3", at[0]);
      end
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (pcs[i] !== exp_pcs[i] || ins[i] !== mem_word(exp_pcs[i])) begin
          n_bad++;
          $display("FAIL seq_pc%0d: got %h/%h want %h/%h", i, pcs[i],
                   ins[i], exp_pcs[i], mem_word(exp_pcs[i]));
        end
        if (i > 0) begin
          n_cmp++;
          if (at[i] - at[i-1] !== 3) begin
            n_bad++;
            $display("FAIL seq_gap%0d: got %0d want 3", i, at[i] - at[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_slow_mem();
    logic        ok = 1'b1;
    logic [31:0] d = $urandom;
    logic [31:0] cpc = 32'h0;
    logic [31:0] cin = 32'h0;
    int          nv = 0;
    start_at(32'h0);
    ok = ok && req === 1'b1 && addr === 32'h0;
    repeat (3) begin
      @(negedge clk);
      ok = ok && req === 1'b1 && addr === 32'h0;
    end
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    ok = ok && req === 1'b0;
    @(negedge clk);
    rvalid = 1'b1;
    rdata  = d;
    @(negedge clk);
    rvalid = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL slow_addr_stable: got 0 want 1");
    end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (ifv) begin
        nv++;
        cpc = ifpc;
        cin = ifinst;
      end
    end
    n_cmp++;
    if (nv !== 1 || cpc !== 32'h0 || cin !== d) begin
      n_bad++;
      $display("FAIL slow_deliver: got n=%0d pc=%h inst=%h want 1 0 %h", nv, cpc, cin, d);
    end
  endtask

  task automatic test_branch_wait();
    logic [31:0] d = $urandom;
    start_at(32'h8);
    gnt = 1'b1;
    @(negedge clk);
    gnt    = 1'b0;
    branch = 1'b1;
    btgt   = 32'h101;
    @(negedge clk);
    branch = 1'b0;
    rvalid = 1'b1;
    rdata  = mem_word(32'h8);
    @(negedge clk);
    rvalid = 1'b0;
    n_cmp++;
    if (ifv !== 1'b0 || req !== 1'b1 || addr !== 32'h100) begin
      n_bad++;
      $display("FAIL br_redirect: got v=%b req=%b addr=%h want 0 1 100", ifv, req, addr);
    end
    gnt = 1'b1;
    @(negedge clk);
    gnt    = 1'b0;
    rvalid = 1'b1;
    rdata  = d;
    @(negedge clk);
    rvalid = 1'b0;
    n_cmp++;
    if (ifv !== 1'b1 || ifpc !== 32'h100 || ifinst !== d) begin
      n_bad++;
      $display("FAIL br_deliver: got %b %h %h want 1 100 %h", ifv, ifpc, ifinst, d);
    end
  endtask

  task automatic test_flush_prio();
    start_at(32'h200);
    flush  = 1'b1;
    new_pc = 32'h20;
    branch = 1'b1;
    btgt   = 32'h400;
    @(negedge clk);
    flush  = 1'b0;
    branch = 1'b0;
    n_cmp++;
    if (req !== 1'b1 || addr !== 32'h20) begin
      n_bad++; $display("FAIL prio_addr: got req=%b addr=%h want 1 20", req, addr);
    end
    gnt = 1'b1;
    @(negedge clk);
    gnt    = 1'b0;
    rvalid = 1'b1;
    rdata  = mem_word(32'h20);
    @(negedge clk);
    rvalid = 1'b0;
    n_cmp++;
    if (ifv !== 1'b1 || ifpc !== 32'h20 || ifinst !== mem_word(32'h20)) begin
      n_bad++; $display("FAIL prio_deliver: got %b %h want 1 20", ifv, ifpc);
    end
    @(negedge clk);
    n_cmp++;
    if (req !== 1'b1 || addr !== 32'h24) begin
      n_bad++; $display("FAIL prio_next: got req=%b addr=%h want 1 24", req, addr);
    end
  endtask

  task automatic test_stall_hold();
    logic        ok = 1'b1;
    logic [31:0] d = $urandom;
    start_at(32'h80);
    stall = 1'b1;
    gnt   = 1'b1;
    @(negedge clk);
    gnt    = 1'b0;
    rvalid = 1'b1;
    rdata  = d;
    @(negedge clk);
    rvalid = 1'b0;
    n_cmp++;
    if (ifv !== 1'b1 || ifpc !== 32'h80 || ifinst !== d) begin
      n_bad++; $display("FAIL hold_first: got %b %h %h want 1 80 %h", ifv, ifpc, ifinst, d);
    end
    repeat (5) begin
      @(negedge clk);
      ok = ok && ifv === 1'b1 && ifpc === 32'h80 && ifinst === d && req === 1'b0;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL hold_stable: got 0 want 1");
    end
    branch = 1'b1;
    btgt   = 32'h40;
    @(negedge clk);
    branch = 1'b0;
    n_cmp++;
    if (ifv !== 1'b0 || req !== 1'b1 || addr !== 32'h40) begin
      n_bad++;
      $display("FAIL hold_branch: got v=%b req=%b addr=%h want 0 1 40", ifv, req, addr);
    end
    stall = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    start_at(32'h10);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (ce !== 1'b0 || req !== 1'b0 || addr !== RPC) begin
      n_bad++;
      $display("FAIL async_rst_ctl: got ce=%b req=%b addr=%h want 0 0 %h", ce, req, addr, RPC);
    end
    n_cmp++;
    if (ifv !== 1'b0 || ifpc !== 32'h0 || ifinst !== 32'h0) begin
      n_bad++;
      $display("FAIL async_rst_if: got %b %h %h want 0 0 0", ifv, ifpc, ifinst);
    end
    @(negedge clk);
    rst    = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    n_cmp++;
    if (req !== 1'b1 || addr !== RPC || ifv !== 1'b0) begin
      n_bad++;
      $display("FAIL late_rvalid_req: got req=%b addr=%h v=%b want 1 %h 0", req, addr, ifv, RPC);
    end
    @(negedge clk);
    rvalid = 1'b0;
    n_cmp++;
    if (ifv !== 1'b0) begin
      n_bad++; $display("FAIL late_rvalid_drop: got %b want 0", ifv);
    end
  endtask

  // Reference: delivered PCs run sequentially from the last redirect
  // target, each word equals memory at that PC, and a redirect voids
  // anything not yet delivered.
  task automatic test_random();
    logic [31:0] exp_pc = $urandom & 32'hFFFF_FFFC;
    logic [31:0] tgt;
    logic [31:0] paddr = 32'h0;
    logic        pending = 1'b0;
    logic        pv = 1'b0;
    int          dly = 0;
    int          nd = 0;
    start_at(exp_pc);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (ifv && !pv) begin
        nd++;
        n_cmp++;
        if (ifpc !== exp_pc || ifinst !== mem_word(exp_pc)) begin
          n_bad++;
          $display("FAIL rnd_deliver: got %h/%h want %h/%h", ifpc, ifinst,
                   exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
      pv    = ifv;
      stall = ($urandom_range(0, 9) < 3);
      flush  = 1'b0;
      branch = 1'b0;
      if ($urandom_range(0, 19) == 0) begin
        tgt = $urandom;
        if ($urandom_range(0, 1) == 1) begin
          flush  = 1'b1;
          new_pc = tgt;
          btgt   = $urandom;
        end else begin
          branch = 1'b1;
          btgt   = tgt;
        end
        exp_pc = {tgt[31:2], 2'b00};
      end
      if (pending) begin
        gnt = ($urandom_range(0, 3) == 0);
        if (dly == 0) begin
          rvalid  = 1'b1;
          rdata   = mem_word(paddr);
          pending = 1'b0;
        end else begin
          dly--;
          rvalid = 1'b0;
          rdata  = $urandom;
        end
      end else begin
        rvalid = ($urandom_range(0, 9) == 0);
        rdata  = $urandom;
        if (req) begin
          gnt = ($urandom_range(0, 1) == 1);
          if (gnt) begin
            pending = 1'b1;
            paddr   = addr;
            dly     = $urandom_range(0, 3);
          end
        end else begin
          gnt = ($urandom_range(0, 3) == 0);
        end
      end
      @(negedge clk);
    end
    idle_inputs();
    n_cmp++;
    if (nd < 50) begin
      n_bad++; $display("FAIL rnd_progress: got %0d want >=50", nd);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_wrap_seq();
    test_slow_mem();
    test_branch_wait();
    test_flush_prio();
    test_stall_hold();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
